fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0, byte address of first instruction after start.
REQ-002 SHALL have parameter IMEM_AW, default 15, word-address width of instruction memory.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle pulse beginning execution from RESET_PC.
REQ-006 SHALL have port hold  input  1  downstream stall; freezes issue while high.
REQ-007 SHALL have port npc  input  32  next PC from decode, valid while valid=1.
REQ-008 SHALL have port wait_time  input  5  extra stall cycles requested by decode for the issued instruction.
REQ-009 SHALL have port stop  input  1  decode reports halt instruction.
REQ-010 SHALL have port imem_en  output  1  instruction memory read enable.
REQ-011 SHALL have port imem_addr  output  IMEM_AW  word address, equal to pc[IMEM_AW+1:2].
REQ-012 SHALL have port imem_data  input  32  synchronous memory read data, valid one cycle after imem_en.
REQ-013 SHALL have port pc  output  32  byte address of the instruction presented.
REQ-014 SHALL have port inst  output  32  instruction word presented to decode.
REQ-015 SHALL have port valid  output  1  pc/inst are a live instruction this cycle.
REQ-016 SHALL have port halted  output  1  stop executed; fetch idle until restart.

Function
REQ-017 SHALL implement states IDLE, FETCH, ISSUE, WAIT, HALT.
REQ-018 IDLE: on start, pc<=RESET_PC, next state FETCH; otherwise remain.
REQ-019 FETCH (exactly 1 cycle): imem_en=1, imem_addr from current pc; next state ISSUE.
REQ-020 On entry to ISSUE, inst SHALL capture imem_data; inst is held constant until the next ISSUE entry.
REQ-021 ISSUE: valid=1; if hold=1 remain in ISSUE with pc/inst unchanged and do not sample npc/wait_time/stop.
REQ-022 ISSUE with hold=0 and stop=1: next state HALT; pc unchanged; npc and wait_time ignored.
REQ-023 ISSUE with hold=0, stop=0, wait_time=0: pc<=npc, next state FETCH.
REQ-024 ISSUE with hold=0, stop=0, wait_time=N>0: latch npc into a pending register, counter<=N, next state WAIT.
REQ-025 WAIT: counter decrements each cycle; exactly N cycles spent in WAIT; on the cycle counter=1, pc<=pending npc, next state FETCH.
REQ-026 hold SHALL have no effect outside ISSUE; WAIT always completes in N cycles.
REQ-027 Issue spacing: consecutive valid rising edges SHALL be 2+wait_time cycles apart when hold stays 0.
REQ-028 npc[1:0] SHALL be stored but ignored for imem_addr; upper bits beyond IMEM_AW+1 SHALL be ignored for addressing (wrap modulo memory size).
REQ-029 HALT: halted=1, valid=0, imem_en=0; on start, pc<=RESET_PC, halted<=0, next state FETCH.
REQ-030 start SHALL be ignored in FETCH, ISSUE, WAIT.
REQ-031 valid and imem_en SHALL be decoded from state only (registered state, no combinational input paths).

Reset
REQ-032 rstn=0 SHALL immediately, regardless of clk, force state IDLE, pc=0, inst=0, pending npc=0, counter=0, valid=0, imem_en=0, halted=0.
REQ-033 Reset asserted mid-WAIT or mid-ISSUE SHALL abandon the instruction; no state survives.
REQ-034 start SHALL be ignored while rstn=0 and on the edge at which rstn deasserts.

Verification
REQ-035 Reset, start at cycle 0, imem[0]=0x20010005, npc=4, wait_time=0 -> imem_en=1 addr 0 at cycle 1; valid=1, pc=0, inst=0x20010005 at cycle 2; imem_addr=1 at cycle 3; valid with pc=4 at cycle 4.
REQ-036 Issue at cycle t with wait_time=5, npc=8 -> valid=0 for cycles t+1..t+6, imem_addr=2 at t+6, next valid at t+7 with pc=8.
REQ-037 npc=0x00000100 (jump) -> next imem_addr=0x40, pc=0x100; npc=0x103 -> same imem_addr=0x40.
REQ-038 hold=1 for 3 cycles in ISSUE -> valid high 4 consecutive cycles, pc/inst constant; npc sampled only on the hold=0 cycle.
REQ-039 stop=1 at ISSUE -> halted=1 next cycle, valid=0 and imem_en=0 thereafter; start pulse -> halted=0, FETCH with pc=RESET_PC.
REQ-040 rstn low during WAIT (counter=3) -> all outputs zero asynchronously; after release, no valid until a start pulse.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: fetches one word per instruction from a synchronous
// instruction memory, presents it to decode, and paces issue by decode's stall requests.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          IMEM_AW  = 15
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic               hold,
  input  logic [31:0]        npc,
  input  logic [4:0]         wait_time,
  input  logic               stop,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_data,
  output logic [31:0]        pc,
  output logic [31:0]        inst,
  output logic               valid,
  output logic               halted
);

  // state | meaning
  // IDLE  | out of reset, waiting for start
  // FETCH | memory read of the word at pc
  // ISSUE | instruction presented to decode (valid)
  // WAIT  | decode-requested stall, counter runs down to 1
  // HALT  | stop executed, waiting for start
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  logic [2:0]  state;
  logic [31:0] pc_r;
  logic [31:0] inst_r;
  logic [31:0] pend_npc;
  logic [4:0]  cnt;
  logic        armed;
  logic        first_issue;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= S_IDLE;
      pc_r        <= 32'h0;
      inst_r      <= 32'h0;
      pend_npc    <= 32'h0;
      cnt         <= 5'd0;
      armed       <= 1'b0;
      first_issue <= 1'b0;
    end else begin
      // armed blocks a start sampled on the same edge that reset is released
      armed       <= 1'b1;
      first_issue <= (state == S_FETCH);
      if (first_issue) inst_r <= imem_data;
      case (state)
        S_IDLE, S_HALT: begin
          if (start && armed) begin
            pc_r  <= RESET_PC;
            state <= S_FETCH;
          end
        end
        S_FETCH: state <= S_ISSUE;
        S_ISSUE: begin
          if (!hold) begin
            if (stop) begin
              state <= S_HALT;
            end else if (wait_time == 5'd0) begin
              pc_r  <= npc;
              state <= S_FETCH;
            end else begin
              pend_npc <= npc;
              cnt      <= wait_time;
              state    <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          cnt <= cnt - 5'd1;
          if (cnt == 5'd1) begin
            pc_r  <= pend_npc;
            state <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Read data only arrives during the first ISSUE cycle, so it is forwarded then and held after.
  assign inst      = first_issue ? imem_data : inst_r;
  assign pc        = pc_r;
  assign imem_addr = pc_r[IMEM_AW+1:2];
  assign imem_en   = (state == S_FETCH);
  assign valid     = (state == S_ISSUE);
  assign halted    = (state == S_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vectors, hand sequences for
// hold/halt/reset corners, and a randomized run against a timing-level model.
module tb_fetch_unit;
  localparam int          AW  = 15;
  localparam logic [31:0] RPC = 32'h0;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic          hold = 1'b0;
  logic          stop = 1'b0;
  logic [31:0]   npc = 32'h0;
  logic [4:0]    wait_time = 5'd0;
  logic          imem_en;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_data = 32'h0;
  logic [31:0]   pc;
  logic [31:0]   inst;
  logic          valid;
  logic          halted;

  int tests = 0;
  int fails = 0;

  fetch_unit #(.RESET_PC(RPC), .IMEM_AW(AW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .hold(hold), .npc(npc),
    .wait_time(wait_time), .stop(stop), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_data(imem_data), .pc(pc), .inst(inst), .valid(valid), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [AW-1:0] a);
    if (a == '0) return 32'h20010005;
    return ({17'b0, a} * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  always @(posedge clk) if (imem_en) imem_data <= word_of(imem_addr);

  typedef struct {
    logic [31:0]   npc;
    logic [4:0]    wt;
    int            gap;
    logic [AW-1:0] addr;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"},  32'(valid),     32'h0);
    chk({tag, "_en"},     32'(imem_en),   32'h0);
    chk({tag, "_halted"}, 32'(halted),    32'h0);
    chk({tag, "_pc"},     pc,             32'h0);
    chk({tag, "_inst"},   inst,           32'h0);
    chk({tag, "_addr"},   32'(imem_addr), 32'h0);
  endtask

  task automatic do_reset;
    rstn = 1'b0; start = 1'b0; hold = 1'b0; stop = 1'b0; npc = '0; wait_time = '0;
    #1 chk_all_zero("reset");
    step(); step();
    rstn = 1'b1;
    step(); step();
  endtask

  task automatic wait_valid(input int max_cyc, output int n, output logic [AW-1:0] faddr);
    n = 0;
    faddr = '0;
    while (valid !== 1'b1 && n < max_cyc) begin
      if (imem_en) faddr = imem_addr;
      step();
      n++;
    end
    chk("valid_timeout", 32'(valid), 32'h1);
  endtask

  int            n;
  logic [AW-1:0] fa;
  logic [31:0]   p_pc, p_inst;

  // timing-level model state for the randomized run
  bit          m_run, m_halt, exp_valid, exp_en;
  logic [31:0] m_pc;
  int          m_issue;

  initial begin
    vecs[0] = '{npc: 32'h0000_0008, wt: 5'd5,  gap: 7,  addr: 15'h0002};
    vecs[1] = '{npc: 32'h0000_0100, wt: 5'd0,  gap: 2,  addr: 15'h0040};
    vecs[2] = '{npc: 32'h0000_0103, wt: 5'd0,  gap: 2,  addr: 15'h0040};
    vecs[3] = '{npc: 32'hFFFF_FFFC, wt: 5'd1,  gap: 3,  addr: 15'h7FFF};
    vecs[4] = '{npc: 32'h0002_0010, wt: 5'd31, gap: 33, addr: 15'h0004};
    vecs[5] = '{npc: 32'h0000_0024, wt: 5'd2,  gap: 4,  addr: 15'h0009};

    do_reset();

    // first instruction: start in cycle 0
    npc = 32'h4; wait_time = 5'd0; start = 1'b1;
    step(); start = 1'b0;
    chk("c1_en", 32'(imem_en), 32'h1);
    chk("c1_addr", 32'(imem_addr), 32'h0);
    chk("c1_valid", 32'(valid), 32'h0);
    step();
    chk("c2_valid", 32'(valid), 32'h1);
    chk("c2_pc", pc, 32'h0);
    chk("c2_inst", inst, 32'h20010005);
    step();
    chk("c3_en", 32'(imem_en), 32'h1);
    chk("c3_addr", 32'(imem_addr), 32'h1);
    step();
    chk("c4_valid", 32'(valid), 32'h1);
    chk("c4_pc", pc, 32'h4);
    chk("c4_inst", inst, word_of(15'h1));

    foreach (vecs[i]) begin
      p_inst = inst;
      npc = vecs[i].npc; wait_time = vecs[i].wt;
      step();
      npc = 32'h0; wait_time = 5'd0;
      chk("vec_inst_hold", inst, p_inst);
      wait_valid(40, n, fa);
      chk("vec_gap", 32'(n + 1), 32'(vecs[i].gap));
      chk("vec_addr", 32'(fa), 32'(vecs[i].addr));
      chk("vec_pc", pc, vecs[i].npc);
      chk("vec_inst", inst, word_of(vecs[i].addr));
    end

    // hold for 3 cycles: decode inputs must not be sampled while held
    p_pc = pc; p_inst = inst;
    hold = 1'b1; stop = 1'b1; npc = 32'hDEAD_0000; wait_time = 5'd3;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("hold_valid", 32'(valid), 32'h1);
      chk("hold_pc", pc, p_pc);
      chk("hold_inst", inst, p_inst);
    end
    hold = 1'b0; stop = 1'b0; npc = 32'h40; wait_time = 5'd0;
    step();
    npc = 32'h0;
    chk("hold_release_valid", 32'(valid), 32'h0);
    wait_valid(10, n, fa);
    chk("hold_gap", 32'(n + 1), 32'h2);
    chk("hold_next_pc", pc, 32'h40);

    // stop, then restart
    stop = 1'b1; npc = 32'h80; wait_time = 5'd4;
    step();
    stop = 1'b0; npc = 32'h0; wait_time = 5'd0;
    chk("halt_halted", 32'(halted), 32'h1);
    chk("halt_valid", 32'(valid), 32'h0);
    chk("halt_pc", pc, 32'h40);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("halt_stay", {30'b0, imem_en, valid}, 32'h0);
      chk("halt_stay_h", 32'(halted), 32'h1);
    end
    start = 1'b1;
    step(); start = 1'b0;
    chk("restart_halted", 32'(halted), 32'h0);
    chk("restart_en", 32'(imem_en), 32'h1);
    chk("restart_addr", 32'(imem_addr), 32'(RPC[AW+1:2]));
    step();
    chk("restart_valid", 32'(valid), 32'h1);
    chk("restart_pc", pc, RPC);

    // reset asserted in WAIT with counter=3, start ignored around release
    npc = 32'h8; wait_time = 5'd5;
    step();
    npc = 32'h0; wait_time = 5'd0; start = 1'b1;
    step(); step();
    chk("wait_ignores_start", {30'b0, imem_en, valid}, 32'h0);
    #1 rstn = 1'b0;
    #1 chk_all_zero("async_rst");
    step(); step();
    rstn = 1'b1;
    step(); start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("post_rst_idle", {30'b0, imem_en, valid}, 32'h0);
      step();
    end
    start = 1'b1;
    step(); start = 1'b0;
    wait_valid(5, n, fa);
    chk("post_rst_start_pc", pc, RPC);

    // randomized run against the timing model
    do_reset();
    m_run = 0; m_halt = 0; m_pc = 32'h0; m_issue = 0;
    for (int i = 0; i < 3000; i++) begin
      exp_valid = m_run && (i >= m_issue);
      exp_en    = m_run && (i == m_issue - 1);
      chk("rnd_valid", 32'(valid), 32'(exp_valid));
      chk("rnd_en", 32'(imem_en), 32'(exp_en));
      chk("rnd_halted", 32'(halted), 32'(m_halt));
      if (exp_valid) begin
        chk("rnd_pc", pc, m_pc);
        chk("rnd_inst", inst, word_of(m_pc[AW+1:2]));
      end
      if (exp_en) chk("rnd_addr", 32'(imem_addr), 32'(m_pc[AW+1:2]));

      start     = ($urandom_range(0, 19) == 0);
      hold      = ($urandom_range(0, 2) == 0);
      stop      = ($urandom_range(0, 24) == 0);
      npc       = $urandom;
      wait_time = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 7)) : 5'd0;

      if (!m_run && start) begin
        m_run = 1; m_halt = 0; m_pc = RPC; m_issue = i + 2;
      end else if (exp_valid && !hold) begin
        if (stop) begin
          m_run = 0; m_halt = 1;
        end else begin
          m_pc = npc; m_issue = i + 2 + int'(wait_time);
        end
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
